// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// DMemReq rises with WE/Addr/WData/BE stable and holds until DMemAck is seen high at an edge; DMemRData is valid only with DMemAck.
interface mem_access_stage_if;
   logic        DMemReq;
   logic        DMemWE;
   logic [31:0] DMemAddr;
   logic [31:0] DMemWData;
   logic [3:0]  DMemBE;
   logic [31:0] DMemRData;
   logic        DMemAck;

   modport master (
      output DMemReq, DMemWE, DMemAddr, DMemWData, DMemBE,
      input  DMemRData, DMemAck
   );

   modport slave (
      input  DMemReq, DMemWE, DMemAddr, DMemWData, DMemBE,
      output DMemRData, DMemAck
   );
endinterface

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: byte/half/word accesses over a req/ack bus with timeout, upstream stall and MEM/WB register.
// Optional feature macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses are dropped and flagged on AlignErr.
module mem_access_stage #(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [31:0] ALUResultIn,
   input  logic [31:0] RD2in,
   input  logic [4:0]  WRin,
   input  logic        regWIn,
   input  logic [1:0]  MemtoRegIn,
   input  logic [1:0]  MemRIn,
   input  logic [1:0]  MemWIn,
   input  logic [31:0] PCDisplayIn,
   input  logic        SADSigIn,
   mem_access_stage_if.master dmem,
   output logic        MemStall,
   output logic [31:0] ALUResultOut,
   output logic [31:0] MemDataOut,
   output logic [31:0] PCDisplayOut,
   output logic [4:0]  WROut,
   output logic        regWOut,
   output logic [1:0]  MemtoRegOut,
   output logic        SADSigOut,
   output logic        BusErr,
   output logic        AlignErr,
   output logic [1:0]  StateDbg
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic        req_q, req_d, we_q, we_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, buf_q, buf_d;
   logic [3:0]  be_q, be_d;
   logic [1:0]  size_q, size_d, off_q, off_d;
   logic        buserr_q, buserr_d, alignerr_q, alignerr_d;
   logic [31:0] h_alu_q, h_alu_d, h_pc_q, h_pc_d;
   logic [4:0]  h_wr_q, h_wr_d;
   logic        h_regw_q, h_regw_d, h_sad_q, h_sad_d;
   logic [1:0]  h_m2r_q, h_m2r_d;
   logic [31:0] alu_out_q, alu_out_d, mdata_q, mdata_d, pc_out_q, pc_out_d;
   logic [4:0]  wr_out_q, wr_out_d;
   logic        regw_out_q, regw_out_d, sad_out_q, sad_out_d;
   logic [1:0]  m2r_out_q, m2r_out_d;

   logic [1:0]  op_size, op_off;
   logic        op_we, op_present, trap;
   logic [3:0]  op_be;
   logic [31:0] op_wdata, rd_ext;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   // A write wins when both read and write sizes are set.
   assign op_we      = (MemWIn != 2'b00);
   assign op_size    = op_we ? MemWIn : MemRIn;
   assign op_present = (op_size != 2'b00);

`ifdef MEM_MISALIGN_TRAP_EN
   assign trap = ((op_size == 2'b10) && ALUResultIn[0]) ||
                 ((op_size == 2'b01) && (ALUResultIn[1:0] != 2'b00));
`else
   assign trap = 1'b0;
`endif

   always_comb begin
      op_off   = ALUResultIn[1:0];
      op_be    = 4'b0000;
      op_wdata = RD2in;
      case (op_size)
         2'b01: begin
            op_off = 2'b00;
            op_be  = 4'b1111;
         end
         2'b10: begin
            op_off   = {ALUResultIn[1], 1'b0};
            op_be    = ALUResultIn[1] ? 4'b1100 : 4'b0011;
            op_wdata = {2{RD2in[15:0]}};
         end
         2'b11: begin
            op_be    = 4'b0001 << ALUResultIn[1:0];
            op_wdata = {4{RD2in[7:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      case (off_q)
         2'b00:   rd_byte = dmem.DMemRData[7:0];
         2'b01:   rd_byte = dmem.DMemRData[15:8];
         2'b10:   rd_byte = dmem.DMemRData[23:16];
         default: rd_byte = dmem.DMemRData[31:24];
      endcase
      rd_half = off_q[1] ? dmem.DMemRData[31:16] : dmem.DMemRData[15:0];
      case (size_q)
         2'b11:   rd_ext = {{24{rd_byte[7]}}, rd_byte};
         2'b10:   rd_ext = {{16{rd_half[15]}}, rd_half};
         default: rd_ext = dmem.DMemRData;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      size_d     = size_q;
      off_d      = off_q;
      buf_d      = buf_q;
      buserr_d   = buserr_q;
      alignerr_d = 1'b0;
      h_alu_d    = h_alu_q;
      h_pc_d     = h_pc_q;
      h_wr_d     = h_wr_q;
      h_regw_d   = h_regw_q;
      h_m2r_d    = h_m2r_q;
      h_sad_d    = h_sad_q;
      alu_out_d  = alu_out_q;
      mdata_d    = mdata_q;
      pc_out_d   = pc_out_q;
      wr_out_d   = wr_out_q;
      regw_out_d = regw_out_q;
      m2r_out_d  = m2r_out_q;
      sad_out_d  = sad_out_q;
      MemStall   = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (op_present && !trap) begin
               MemStall = 1'b1;
               req_d    = 1'b1;
               we_d     = op_we;
               addr_d   = {ALUResultIn[31:2], 2'b00};
               wdata_d  = op_wdata;
               be_d     = op_be;
               size_d   = op_size;
               off_d    = op_off;
               h_alu_d  = ALUResultIn;
               h_pc_d   = PCDisplayIn;
               h_wr_d   = WRin;
               h_regw_d = regWIn;
               h_m2r_d  = MemtoRegIn;
               h_sad_d  = SADSigIn;
               state_d  = REQ;
            end
            if (op_present) begin
               alignerr_d = trap;
               alu_out_d  = '0;
               mdata_d    = '0;
               pc_out_d   = '0;
               wr_out_d   = '0;
               regw_out_d = 1'b0;
               m2r_out_d  = '0;
               sad_out_d  = 1'b0;
            end else begin
               alu_out_d  = ALUResultIn;
               mdata_d    = '0;
               pc_out_d   = PCDisplayIn;
               wr_out_d   = WRin;
               regw_out_d = regWIn;
               m2r_out_d  = MemtoRegIn;
               sad_out_d  = SADSigIn;
            end
         end
         REQ: begin
            MemStall = 1'b1;
            cnt_d    = cnt_q + 1'b1;
            if (dmem.DMemAck) begin
               buf_d   = we_q ? 32'd0 : rd_ext;
               req_d   = 1'b0;
               state_d = DONE;
            end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
               buf_d    = '0;
               req_d    = 1'b0;
               buserr_d = 1'b1;
               state_d  = DONE;
            end
         end
         DONE: begin
            alu_out_d  = h_alu_q;
            mdata_d    = buf_q;
            pc_out_d   = h_pc_q;
            wr_out_d   = h_wr_q;
            regw_out_d = h_regw_q;
            m2r_out_d  = h_m2r_q;
            sad_out_d  = h_sad_q;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         size_q     <= '0;
         off_q      <= '0;
         buf_q      <= '0;
         buserr_q   <= 1'b0;
         alignerr_q <= 1'b0;
         h_alu_q    <= '0;
         h_pc_q     <= '0;
         h_wr_q     <= '0;
         h_regw_q   <= 1'b0;
         h_m2r_q    <= '0;
         h_sad_q    <= 1'b0;
         alu_out_q  <= '0;
         mdata_q    <= '0;
         pc_out_q   <= '0;
         wr_out_q   <= '0;
         regw_out_q <= 1'b0;
         m2r_out_q  <= '0;
         sad_out_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         size_q     <= size_d;
         off_q      <= off_d;
         buf_q      <= buf_d;
         buserr_q   <= buserr_d;
         alignerr_q <= alignerr_d;
         h_alu_q    <= h_alu_d;
         h_pc_q     <= h_pc_d;
         h_wr_q     <= h_wr_d;
         h_regw_q   <= h_regw_d;
         h_m2r_q    <= h_m2r_d;
         h_sad_q    <= h_sad_d;
         alu_out_q  <= alu_out_d;
         mdata_q    <= mdata_d;
         pc_out_q   <= pc_out_d;
         wr_out_q   <= wr_out_d;
         regw_out_q <= regw_out_d;
         m2r_out_q  <= m2r_out_d;
         sad_out_q  <= sad_out_d;
      end
   end

   assign dmem.DMemReq   = req_q;
   assign dmem.DMemWE    = we_q;
   assign dmem.DMemAddr  = addr_q;
   assign dmem.DMemWData = wdata_q;
   assign dmem.DMemBE    = be_q;
   assign ALUResultOut   = alu_out_q;
   assign MemDataOut     = mdata_q;
   assign PCDisplayOut   = pc_out_q;
   assign WROut          = wr_out_q;
   assign regWOut        = regw_out_q;
   assign MemtoRegOut    = m2r_out_q;
   assign SADSigOut      = sad_out_q;
   assign BusErr         = buserr_q;
   assign AlignErr       = alignerr_q;
   assign StateDbg       = state_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: memory responder with programmable ack latency plus MEM/WB scoreboard.
module tb_mem_access_stage;
   localparam int TO = 16;

   logic        Clk = 1'b0;
   logic        Rst = 1'b0;
   logic [31:0] ALUResultIn, RD2in, PCDisplayIn;
   logic [4:0]  WRin;
   logic        regWIn, SADSigIn;
   logic [1:0]  MemtoRegIn, MemRIn, MemWIn;
   logic        MemStall, regWOut, SADSigOut, BusErr, AlignErr;
   logic [31:0] ALUResultOut, MemDataOut, PCDisplayOut;
   logic [4:0]  WROut;
   logic [1:0]  MemtoRegOut, StateDbg;

   mem_access_stage_if dmem ();

   mem_access_stage #(.TIMEOUT_CYC(TO)) dut (
      .Clk(Clk), .Rst(Rst),
      .ALUResultIn(ALUResultIn), .RD2in(RD2in), .WRin(WRin), .regWIn(regWIn),
      .MemtoRegIn(MemtoRegIn), .MemRIn(MemRIn), .MemWIn(MemWIn),
      .PCDisplayIn(PCDisplayIn), .SADSigIn(SADSigIn),
      .dmem(dmem),
      .MemStall(MemStall), .ALUResultOut(ALUResultOut), .MemDataOut(MemDataOut),
      .PCDisplayOut(PCDisplayOut), .WROut(WROut), .regWOut(regWOut),
      .MemtoRegOut(MemtoRegOut), .SADSigOut(SADSigOut),
      .BusErr(BusErr), .AlignErr(AlignErr), .StateDbg(StateDbg)
   );

   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_pass   = 0;
   logic [104:0] exp_q[$];

   int          ack_lat   = 1;
   bit          ack_en    = 1'b1;
   bit          stale_ack = 1'b0;
   logic [31:0] rd_word   = '0;
   int          req_cycles = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [104:0] mewb(input logic [31:0] alu, mdata, input logic [4:0] wr,
                                         input logic rw, input logic [1:0] m2r, input logic sad,
                                         input logic [31:0] pc);
      return {alu, mdata, wr, rw, m2r, sad, pc};
   endfunction

   function automatic logic [104:0] mewb_act();
      return mewb(ALUResultOut, MemDataOut, WROut, regWOut, MemtoRegOut, SADSigOut, PCDisplayOut);
   endfunction

   function automatic logic [69:0] bus_act();
      return {dmem.DMemReq, dmem.DMemWE, dmem.DMemAddr, dmem.DMemWData, dmem.DMemBE};
   endfunction

   function automatic logic [3:0] be_model(input logic [1:0] sz, input logic [1:0] off);
      if (sz == 2'b01) return 4'b1111;
      if (sz == 2'b10) return off[1] ? 4'b1100 : 4'b0011;
      return 4'b0001 << off;
   endfunction

   function automatic logic [31:0] wdata_model(input logic [1:0] sz, input logic [31:0] d);
      if (sz == 2'b01) return d;
      if (sz == 2'b10) return {d[15:0], d[15:0]};
      return {d[7:0], d[7:0], d[7:0], d[7:0]};
   endfunction

   function automatic logic [31:0] load_model(input logic [1:0] sz, input logic [1:0] off, input logic [31:0] w);
      logic [31:0] s;
      s = w >> (8 * off);
      if (sz == 2'b11) return {{24{s[7]}}, s[7:0]};
      if (sz == 2'b10) return {{16{s[15]}}, s[15:0]};
      return w;
   endfunction

   // Memory responder: ack after ack_lat request cycles; stale_ack drives ack while no request is up.
   initial begin
      dmem.DMemAck   = 1'b0;
      dmem.DMemRData = '0;
      forever begin
         @(posedge Clk); #1;
         if (dmem.DMemReq) begin
            req_cycles++;
            if (ack_en && req_cycles == ack_lat) begin
               dmem.DMemAck   = 1'b1;
               dmem.DMemRData = rd_word;
            end else begin
               dmem.DMemAck   = 1'b0;
               dmem.DMemRData = $urandom;
            end
         end else begin
            req_cycles     = 0;
            dmem.DMemAck   = stale_ack;
            dmem.DMemRData = $urandom;
         end
      end
   end

   task automatic drive(input logic [31:0] alu, rd2, input logic [4:0] wr, input logic rw,
                        input logic [1:0] m2r, mr, mw, input logic [31:0] pc, input logic sad);
      ALUResultIn = alu; RD2in = rd2; WRin = wr; regWIn = rw;
      MemtoRegIn = m2r; MemRIn = mr; MemWIn = mw; PCDisplayIn = pc; SADSigIn = sad;
   endtask

   // Called #1 after an edge; returns #1 after the edge that loads MEM/WB for this instruction.
   task automatic exec(input string tag, input logic [31:0] alu, rd2, input logic [4:0] wr,
                       input logic rw, input logic [1:0] m2r, mr, mw, input logic [31:0] pc,
                       input logic sad, input logic [31:0] exp_mdata, input int exp_stall,
                       input logic [31:0] exp_addr, input logic [3:0] exp_be,
                       input logic [31:0] exp_wdata);
      int  stalls = 0;
      bit  done   = 1'b0;
      bit  is_mem = (mr != 2'b00) || (mw != 2'b00);
      drive(alu, rd2, wr, rw, m2r, mr, mw, pc, sad);
      exp_q.push_back(mewb(alu, exp_mdata, wr, rw, m2r, sad, pc));
      for (int c = 0; c < 64 && !done; c++) begin
         @(negedge Clk);
         if (MemStall) begin
            stalls++;
            if (stalls == 2) check({tag, "_bubble"}, mewb_act(), '0);
         end else begin
            done = 1'b1;
         end
      end
      if (!done) check({tag, "_stall_timeout"}, 0, 1);
      @(posedge Clk); #1;
      if (exp_q.size() == 0) check({tag, "_sb_empty"}, 0, 1);
      else check({tag, "_mewb"}, mewb_act(), exp_q.pop_front());
      check({tag, "_stalls"}, stalls, exp_stall);
      if (is_mem)
         check({tag, "_bus"}, bus_act(), {1'b0, (mw != 2'b00), exp_addr, exp_wdata, exp_be});
   endtask

   initial begin
      logic [31:0] a, d, md;
      logic [1:0]  sz, mr, mw;
      bit          wr_op;

      drive('0, '0, '0, 1'b0, '0, '0, '0, '0, 1'b0);
      Rst = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      check("rst_bus", bus_act(), '0);
      check("rst_mewb", mewb_act(), '0);
      check("rst_flags", {BusErr, AlignErr, MemStall, StateDbg}, '0);
      Rst = 1'b1;

      exec("add", 32'h10, 32'h0, 5'd5, 1'b1, 2'd0, 2'b00, 2'b00, 32'h1000, 1'b0,
           32'h0, 0, 32'h0, 4'h0, 32'h0);

      ack_lat = 1; rd_word = 32'h8000_0000;
      exec("lb", 32'h103, 32'h0, 5'd8, 1'b1, 2'd1, 2'b11, 2'b00, 32'h1004, 1'b0,
           32'hFFFF_FF80, 2, 32'h100, 4'b1000, 32'h0);

      ack_lat = 3; rd_word = $urandom;
      exec("sh", 32'h202, 32'h1234_ABCD, 5'd7, 1'b0, 2'd0, 2'b00, 2'b10, 32'h1008, 1'b1,
           32'h0, 4, 32'h200, 4'b1100, 32'hABCD_ABCD);

      ack_lat = 2; rd_word = 32'h0000_8001;
      exec("lh_lo", 32'h300, 32'h0, 5'd9, 1'b1, 2'd1, 2'b10, 2'b00, 32'h100C, 1'b0,
           32'hFFFF_8001, 3, 32'h300, 4'b0011, 32'h0);
      check("buserr_clear", BusErr, 1'b0);

      ack_en = 1'b0;
      exec("lw_timeout", 32'h40, 32'h0, 5'd3, 1'b1, 2'd1, 2'b01, 2'b00, 32'h1010, 1'b0,
           32'h0, TO + 1, 32'h40, 4'b1111, 32'h0);
      check("buserr_set", BusErr, 1'b1);
      ack_en = 1'b1; ack_lat = 1; rd_word = 32'h5566_7788;
      exec("lw_after_to", 32'h44, 32'h0, 5'd4, 1'b1, 2'd1, 2'b01, 2'b00, 32'h1014, 1'b0,
           32'h5566_7788, 2, 32'h44, 4'b1111, 32'h0);
      check("buserr_sticky", BusErr, 1'b1);

      // Reset in the middle of an outstanding request, then a stale ack.
      ack_en = 1'b0;
      drive(32'h80, 32'h0, 5'd2, 1'b1, 2'd1, 2'b01, 2'b00, 32'h1018, 1'b0);
      repeat (3) @(posedge Clk);
      #1;
      check("midreq_req", dmem.DMemReq, 1'b1);
      Rst = 1'b0; stale_ack = 1'b1;
      drive('0, '0, '0, 1'b0, '0, '0, '0, '0, 1'b0);
      @(posedge Clk); #1;
      Rst = 1'b1;
      check("midrst_bus", bus_act(), '0);
      check("midrst_mewb", mewb_act(), '0);
      check("midrst_flags", {BusErr, AlignErr, MemStall, StateDbg}, '0);
      repeat (2) @(posedge Clk);
      #1;
      check("stale_ack_ign", {dmem.DMemReq, StateDbg, BusErr, mewb_act()}, '0);
      stale_ack = 1'b0; ack_en = 1'b1; ack_lat = 1; rd_word = 32'hCAFE_F00D;
      exec("lw_post_rst", 32'h84, 32'h0, 5'd6, 1'b1, 2'd1, 2'b01, 2'b00, 32'h101C, 1'b0,
           32'hCAFE_F00D, 2, 32'h84, 4'b1111, 32'h0);

`ifdef MEM_MISALIGN_TRAP_EN
      drive(32'h6, 32'h0, 5'd10, 1'b1, 2'd1, 2'b01, 2'b00, 32'h1020, 1'b0);
      @(negedge Clk);
      check("trap_nostall", MemStall, 1'b0);
      @(posedge Clk); #1;
      check("trap_pulse", {AlignErr, dmem.DMemReq}, 2'b10);
      check("trap_bubble", mewb_act(), '0);
      drive('0, '0, '0, 1'b0, '0, '0, '0, '0, 1'b0);
      @(posedge Clk); #1;
      check("trap_pulse_end", AlignErr, 1'b0);
`else
      ack_lat = 1; rd_word = 32'h0BAD_BEEF;
      exec("lw_misalign", 32'h6, 32'h0, 5'd10, 1'b1, 2'd1, 2'b01, 2'b00, 32'h1020, 1'b0,
           32'h0BAD_BEEF, 2, 32'h4, 4'b1111, 32'h0);
      check("no_alignerr", AlignErr, 1'b0);
`endif

      for (int i = 0; i < 20; i++) begin
         exec("rnd_nop", $urandom, $urandom, 5'($urandom), 1'($urandom), 2'($urandom),
              2'b00, 2'b00, $urandom, 1'($urandom), 32'h0, 0, 32'h0, 4'h0, 32'h0);
         sz    = 2'($urandom_range(1, 3));
         wr_op = 1'($urandom_range(0, 1));
         a     = $urandom;
         if (sz == 2'b01) a[1:0] = 2'b00;
         if (sz == 2'b10) a[0] = 1'b0;
         d       = $urandom;
         rd_word = $urandom;
         ack_lat = $urandom_range(1, 4);
         mw      = wr_op ? sz : 2'b00;
         mr      = wr_op ? 2'($urandom_range(0, 3)) : sz;
         md      = wr_op ? 32'h0 : load_model(sz, a[1:0], rd_word);
         exec("rnd_mem", a, d, 5'($urandom), 1'($urandom), 2'($urandom), mr, mw, $urandom,
              1'($urandom), md, 1 + ack_lat, {a[31:2], 2'b00}, be_model(sz, a[1:0]),
              wdata_model(sz, d));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage for the VBSME MIPS core: consumes the EX/MEM register outputs, runs byte/half/word data-memory accesses over a req/ack bus with variable latency and timeout, and drives the MEM/WB register. Stalls the upstream pipeline while an access is outstanding. Passes non-memory instructions through in one cycle.

## Interface
- TIMEOUT_CYC, 16: REQ cycles without ack before bus error; counter width `$clog2(TIMEOUT_CYC+1)`.
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous, active-low reset.
- ALUResultIn  in  32  address or ALU result from EX/MEM.
- RD2in  in  32  store data.
- WRin  in  5  destination register.
- regWIn  in  1  register write enable.
- MemtoRegIn  in  2  writeback select, passed through.
- MemRIn, MemWIn  in  2 each  access size: 00 none, 01 word, 10 half, 11 byte.
- PCDisplayIn  in  32  display PC, passed through.
- SADSigIn  in  1  SAD flag, passed through.
- DMemRData  in  32  memory read data, valid with DMemAck.
- DMemAck  in  1  memory completion.
- DMemReq  out  1  request, registered.
- DMemWE  out  1  1 = write.
- DMemAddr  out  32  word address {ALUResultIn[31:2],2'b00}, latched.
- DMemWData  out  32  store data replicated across lanes.
- DMemBE  out  4  byte enables.
- MemStall  out  1  hold EX/MEM and earlier stages (EXMEMWrite = ~MemStall).
- ALUResultOut, MemDataOut, PCDisplayOut  out  32  MEM/WB fields.
- WROut  out  5; regWOut  out  1; MemtoRegOut  out  2; SADSigOut  out  1.
- BusErr  out  1  sticky timeout flag.
- AlignErr  out  1  one-cycle misalignment pulse.

## Operation
- States: IDLE, REQ, DONE.
- IDLE, no op (MemRIn==MemWIn==0): MemStall=0; MEM/WB captures inputs at edge; MemDataOut=0.
- IDLE, op present: MemStall=1 combinationally; at edge latch address, WE, BE, wdata, size, byte offset; DMemReq→1; go REQ; MEM/WB loads bubble (regWOut=0, WROut=0, other fields 0).
- MemWIn!=0 and MemRIn!=0 together: write only.
- REQ: DMemReq=1, MemStall=1, counter increments. On DMemAck=1 at edge: buffer extracted read data, DMemReq→0, go DONE. When counter reaches TIMEOUT_CYC without ack: DMemReq→0, BusErr→1, buffer=0, go DONE.
- DONE: MemStall=0; at edge MEM/WB captures held EX/MEM fields plus buffer into MemDataOut; go IDLE. Upstream advances on the same edge.
- BE: word 1111; half 0011 or 1100 by ALUResultIn[1]; byte one-hot by ALUResultIn[1:0] (offset 0 → 0001).
- Wdata: word as-is; half {2{RD2in[15:0]}}; byte {4{RD2in[7:0]}}.
- Loads sign-extend: byte lane selected by offset; half by bit 1; word unchanged.
- Write with ack: MemDataOut=0.
- BusErr clears only on reset.
- DMemAck outside REQ ignored.

## Timing
- Non-memory instruction: 1 cycle, no stall.
- Memory op with ack in first REQ cycle: 3 cycles (IDLE, REQ, DONE), 2 stall cycles; ack after k REQ cycles: k+2 cycles.
- Timeout: TIMEOUT_CYC REQ cycles, then DONE.
- Reset (Rst=0 at edge, including mid-REQ): state IDLE, counter 0, DMemReq 0, DMemWE 0, DMemAddr/DMemWData 0, DMemBE 0, BusErr 0, AlignErr 0, all MEM/WB outputs 0. MemStall combinationally follows IDLE rule.
- Outstanding request is abandoned on reset; late ack after reset is ignored.

## Configuration
- MEM_MISALIGN_TRAP_EN defined: half with ALUResultIn[0]=1 or word with ALUResultIn[1:0]!=0 is not issued. AlignErr pulses one cycle, no stall, MEM/WB gets bubble.
- Undefined: offending low address bits forced to 0 (half bit 0; word bits 1:0). Access proceeds. AlignErr tied 0.

## Test plan
- ADD, ALUResultIn=0x10, WRin=5, regWIn=1 -> next edge ALUResultOut=0x10, WROut=5, regWOut=1, MemStall never high.
- LB at 0x103 (MemRIn=11), ack after 1 REQ cycle with DMemRData=0x80000000 -> DMemAddr=0x100, DMemBE=1000; MemDataOut=0xFFFFFF80 after 3 cycles; 2 stall cycles.
- SH at 0x202 (MemWIn=10), RD2in=0x1234ABCD -> DMemWE=1, DMemBE=1100, DMemWData=0xABCDABCD, regWOut=0.
- LW, ack never, TIMEOUT_CYC=16 -> DMemReq drops after 16 REQ cycles; BusErr=1 and stays; MemDataOut=0.
- Rst=0 during REQ, then LW with ack -> all outputs 0; stale ack ignored; new LW completes normally in 3 cycles.
- LW at 0x6: with MEM_MISALIGN_TRAP_EN -> AlignErr 1-cycle pulse, DMemReq stays 0, regWOut=0. Without it -> DMemAddr=0x4, normal load.
